// File: rtl/oam_sprite_evaluator_pkg.sv
// Shared definitions for the OAM sprite evaluation slice.
// Contents:
//   OAM_ENTRIES / OAM_ADDR_W / OAM_ENTRY_W - OAM geometry
//   *_LSB                                   - bit offsets of the entry fields
//   oam_entry_t                             - packed view of one OAM entry
//   eval_state_t                            - evaluator FSM states
package oam_pkg;

    localparam int OAM_ENTRIES = 64;
    localparam int OAM_ADDR_W  = 6;
    localparam int OAM_ENTRY_W = 32;

    localparam int Y_LSB    = 24;
    localparam int TILE_LSB = 16;
    localparam int ATTR_LSB = 8;
    localparam int X_LSB    = 0;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] tile;
        logic [7:0] attr;
        logic [7:0] x;
    } oam_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } eval_state_t;

endpackage

// File: rtl/oam_sprite_evaluator_if.sv
// Bus bundle between the evaluator and its environment: the start/scanline
// request from the timing generator, the OAM read port, the sprite line list
// write port and the status outputs.
// Modports:
//   master - the evaluator (drives address, list writes and status)
//   slave  - the environment (drives start, scanline and OAM read data)
interface oam_sprite_evaluator_if;
    import oam_pkg::*;

    logic                   start;
    logic [7:0]             scanline;
    logic [OAM_ADDR_W-1:0]  oam_read_addr;
    logic [OAM_ENTRY_W-1:0] oam_read_data;
    logic                   list_we;
    logic [2:0]             list_slot;
    logic [OAM_ENTRY_W-1:0] list_entry;
    logic [3:0]             list_row;
    logic                   busy;
    logic                   done;
    logic [3:0]             sprite_count;
    logic                   overflow;

    modport master (
        input  start, scanline, oam_read_data,
        output oam_read_addr, list_we, list_slot, list_entry, list_row,
               busy, done, sprite_count, overflow
    );

    modport slave (
        output start, scanline, oam_read_data,
        input  oam_read_addr, list_we, list_slot, list_entry, list_row,
               busy, done, sprite_count, overflow
    );

endinterface

// File: rtl/oam_sprite_evaluator_hit_test.sv
// Combinational scanline/sprite intersection test.
// Ports:
//   scanline - line being evaluated
//   y        - sprite top line from the OAM entry
//   hit      - sprite covers the scanline
//   row      - row within the sprite (scanline - y), meaningful when hit=1
// Parameter SPRITE_HEIGHT selects 8- or 16-line sprites.
module oam_hit_test #(
    parameter int SPRITE_HEIGHT = 8
) (
    input  logic [7:0] scanline,
    input  logic [7:0] y,
    output logic       hit,
    output logic [3:0] row
);

    // A 9-bit difference exposes the borrow, so sprites whose top lies
    // below the scanline never wrap round into a hit.
    logic [8:0] diff;

    assign diff = {1'b0, scanline} - {1'b0, y};
    assign hit  = !diff[8] && (diff < 9'(SPRITE_HEIGHT));
    assign row  = diff[3:0];

endmodule

// File: rtl/oam_sprite_evaluator.sv
// Per-scanline sprite evaluator. On start it reads all 64 OAM entries
// (1-cycle registered read latency) and writes up to MAX_SPRITES entries
// that intersect the scanline, with their row offsets, to the sprite list.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-low reset
//   bus   - oam_sprite_evaluator_if.master (start/scanline, OAM read port,
//           list write port, busy/done/sprite_count/overflow)
// Build option OAM_EVAL_OVERFLOW_EN: when defined, the scan always covers all
// 64 entries and extra hits raise overflow; otherwise the scan ends as soon
// as the list is full and overflow is tied low.
module oam_sprite_evaluator
    import oam_pkg::*;
#(
    parameter int SPRITE_HEIGHT = 8,
    parameter int MAX_SPRITES   = 8
) (
    input logic clk,
    input logic reset,
    oam_sprite_evaluator_if.master bus
);

    localparam logic [3:0]            MAX_CNT   = 4'(MAX_SPRITES);
    localparam logic [OAM_ADDR_W-1:0] LAST_ADDR = OAM_ADDR_W'(OAM_ENTRIES - 1);

    eval_state_t           state, state_next;
    logic [OAM_ADDR_W-1:0] addr, addr_next;
    logic [7:0]            line_q, line_next;
    logic [3:0]            count, count_next;
`ifdef OAM_EVAL_OVERFLOW_EN
    logic                  ovf, ovf_next;
`endif

    oam_entry_t entry;
    logic       hit;
    logic [3:0] row;
    logic       test_en;

    assign entry = oam_entry_t'(bus.oam_read_data);

    oam_hit_test #(
        .SPRITE_HEIGHT(SPRITE_HEIGHT)
    ) u_hit_test (
        .scanline(line_q),
        .y       (entry.y),
        .hit     (hit),
        .row     (row)
    );

    // Read data lags the address by one cycle, so the first SCAN cycle
    // (address 0 just presented) has nothing valid to test; DRAIN tests 63.
    assign test_en = ((state == SCAN) && (addr != '0)) || (state == DRAIN);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            addr   <= '0;
            line_q <= '0;
            count  <= '0;
`ifdef OAM_EVAL_OVERFLOW_EN
            ovf    <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            addr   <= addr_next;
            line_q <= line_next;
            count  <= count_next;
`ifdef OAM_EVAL_OVERFLOW_EN
            ovf    <= ovf_next;
`endif
        end
    end

    // Next-state sequencing plus the list write decision for the entry
    // whose data is on the read port this cycle.
    always_comb begin
        state_next     = state;
        addr_next      = addr;
        line_next      = line_q;
        count_next     = count;
`ifdef OAM_EVAL_OVERFLOW_EN
        ovf_next       = ovf;
`endif
        bus.list_we    = 1'b0;
        bus.list_slot  = '0;
        bus.list_entry = '0;
        bus.list_row   = '0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = SCAN;
                    addr_next  = '0;
                    line_next  = bus.scanline;
                    count_next = '0;
`ifdef OAM_EVAL_OVERFLOW_EN
                    ovf_next   = 1'b0;
`endif
                end
            end
            SCAN: begin
                if (addr == LAST_ADDR) begin
                    state_next = DRAIN;
                end else begin
                    addr_next = addr + 1'b1;
                end
            end
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (test_en && hit) begin
            if (count != MAX_CNT) begin
                bus.list_we    = 1'b1;
                bus.list_slot  = count[2:0];
                bus.list_entry = entry;
                bus.list_row   = row;
                count_next     = count + 1'b1;
`ifndef OAM_EVAL_OVERFLOW_EN
                // List just filled: nothing more can be stored, finish now.
                if (4'(count + 1'b1) == MAX_CNT) begin
                    state_next = DONE;
                end
`endif
            end
`ifdef OAM_EVAL_OVERFLOW_EN
            else begin
                ovf_next = 1'b1;
            end
`endif
        end
    end

    assign bus.oam_read_addr = addr;
    assign bus.busy          = (state == SCAN) || (state == DRAIN);
    assign bus.done          = (state == DONE);
    assign bus.sprite_count  = count;
`ifdef OAM_EVAL_OVERFLOW_EN
    assign bus.overflow      = ovf;
`else
    assign bus.overflow      = 1'b0;
`endif

endmodule

// File: tb/tb_oam_sprite_evaluator.sv
// Self-checking bench for oam_sprite_evaluator. Two instances share one OAM
// image: dut8 (SPRITE_HEIGHT=8) and dut16 (SPRITE_HEIGHT=16). Expected list
// contents, counts and latency come from a plain-arithmetic model of the
// evaluation rules. Expectations follow OAM_EVAL_OVERFLOW_EN if defined.
// Latency is counted as clock edges from the edge that samples start up to
// and including the edge that samples done=1.
module tb_oam_sprite_evaluator;

    typedef struct packed {
        logic        we;
        logic [2:0]  slot;
        logic [31:0] entry;
        logic [3:0]  row;
        logic        busy;
        logic        done;
        logic [3:0]  cnt;
        logic        ovf;
        logic [5:0]  addr;
    } snap_t;

    logic clk;
    logic reset;
    logic [31:0] oam [64];

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_entries[$];
    int          exp_rows[$];
    int          exp_count;
    int          exp_ovf;
    int          exp_lat;
    logic [31:0] got_entries[$];
    int          got_rows[$];
    int          got_slots[$];

    oam_sprite_evaluator_if bus8();
    oam_sprite_evaluator_if bus16();

    oam_sprite_evaluator #(.SPRITE_HEIGHT(8), .MAX_SPRITES(8)) dut8 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus8)
    );

    oam_sprite_evaluator #(.SPRITE_HEIGHT(16), .MAX_SPRITES(8)) dut16 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus16)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behaves like the OAM block: registered read, one cycle of latency.
    always @(posedge clk) begin
        bus8.oam_read_data  <= oam[bus8.oam_read_addr];
        bus16.oam_read_data <= oam[bus16.oam_read_addr];
    end

    // One comparison: counts it, and reports it if it does not hold.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic setStart(input int sel, input logic value, input logic [7:0] line);
        if (sel == 0) begin
            bus8.start = value;
            bus8.scanline = line;
        end else begin
            bus16.start = value;
            bus16.scanline = line;
        end
    endtask

    task automatic snap(input int sel, output snap_t s);
        if (sel == 0)
            s = '{bus8.list_we, bus8.list_slot, bus8.list_entry, bus8.list_row, bus8.busy,
                  bus8.done, bus8.sprite_count, bus8.overflow, bus8.oam_read_addr};
        else
            s = '{bus16.list_we, bus16.list_slot, bus16.list_entry, bus16.list_row, bus16.busy,
                  bus16.done, bus16.sprite_count, bus16.overflow, bus16.oam_read_addr};
    endtask

    // Reference: walk OAM in priority order, keep the first 8 covering
    // sprites. Entry i is examined i+1 edges after start, so a list that
    // fills on entry i finishes with done sampled at edge i+3.
    task automatic computeModel(input int height, input logic [7:0] line);
        exp_entries.delete();
        exp_rows.delete();
        exp_count = 0;
        exp_ovf = 0;
        exp_lat = 66;
        for (int i = 0; i < 64; i++) begin
            int d;
            d = int'(line) - int'(oam[i][31:24]);
            if (d >= 0 && d < height) begin
                if (exp_count < 8) begin
                    exp_entries.push_back(oam[i]);
                    exp_rows.push_back(d);
                    exp_count++;
`ifndef OAM_EVAL_OVERFLOW_EN
                    if (exp_count == 8) begin
                        exp_lat = i + 3;
                        break;
                    end
`endif
                end else begin
`ifdef OAM_EVAL_OVERFLOW_EN
                    exp_ovf = 1;
`endif
                end
            end
        end
    endtask

    // Pulses start for one edge; the edge it lands on is the start edge.
    task automatic applyStimulus(input int sel, input logic [7:0] line);
        @(negedge clk);
        setStart(sel, 1'b1, line);
    endtask

    // Runs one evaluation and compares everything against the model.
    // pokeAt >= 0 pulses a stray start at that cycle; pokeDone pulses one on
    // the done cycle. Both must be ignored.
    task automatic runEval(input string name, input int sel, input logic [7:0] line,
                           input int pokeAt, input bit pokeDone);
        snap_t s;
        int    k;
        int    lat;
        bit    gotDone;
        computeModel((sel == 0) ? 8 : 16, line);
        got_entries.delete();
        got_rows.delete();
        got_slots.delete();
        applyStimulus(sel, line);
        k = 0;
        lat = -1;
        gotDone = 0;
        while (!gotDone && k < 100) begin
            @(negedge clk);
            setStart(sel, 1'b0, line);
            snap(sel, s);
            if (s.we) begin
                got_entries.push_back(s.entry);
                got_rows.push_back(int'(s.row));
                got_slots.push_back(int'(s.slot));
            end
            if (s.done) begin
                gotDone = 1;
                lat = k + 1;
                if (pokeDone) setStart(sel, 1'b1, ~line);
            end else if (k == pokeAt) begin
                setStart(sel, 1'b1, ~line);
            end
            k++;
        end
        if (!gotDone) checkOutput({name, "_done_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        setStart(sel, 1'b0, line);
        snap(sel, s);
        checkOutput({name, "_busy_after"}, 32'(s.busy), 32'd0);
        checkOutput({name, "_done_after"}, 32'(s.done), 32'd0);
        checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({name, "_count"}, 32'(s.cnt), 32'(exp_count));
        checkOutput({name, "_overflow"}, 32'(s.ovf), 32'(exp_ovf));
        checkOutput({name, "_writes"}, 32'(got_entries.size()), 32'(exp_entries.size()));
        for (int i = 0; i < exp_entries.size() && i < got_entries.size(); i++) begin
            checkOutput($sformatf("%s_slot%0d", name, i), 32'(got_slots[i]), 32'(i));
            checkOutput($sformatf("%s_entry%0d", name, i), got_entries[i], exp_entries[i]);
            checkOutput($sformatf("%s_row%0d", name, i), 32'(got_rows[i]), 32'(exp_rows[i]));
        end
    endtask

    task automatic fillOam(input logic [7:0] y);
        for (int i = 0; i < 64; i++) oam[i] = {y, 8'(i), 8'(i * 3), 8'(255 - i)};
    endtask

    // Directed scenarios first, then randomized evaluations.
    initial begin
        snap_t s;
        int    n;
        $display("[TB] start");
        reset = 1'b0;
        setStart(0, 1'b0, 8'd0);
        setStart(1, 1'b0, 8'd0);
        fillOam(8'd200);
        repeat (3) @(negedge clk);
        snap(0, s);
        checkOutput("rst_addr", 32'(s.addr), 32'd0);
        checkOutput("rst_we", 32'(s.we), 32'd0);
        checkOutput("rst_slot", 32'(s.slot), 32'd0);
        checkOutput("rst_entry", s.entry, 32'd0);
        checkOutput("rst_row", 32'(s.row), 32'd0);
        checkOutput("rst_busy", 32'(s.busy), 32'd0);
        checkOutput("rst_done", 32'(s.done), 32'd0);
        checkOutput("rst_count", 32'(s.cnt), 32'd0);
        checkOutput("rst_ovf", 32'(s.ovf), 32'd0);
        reset = 1'b1;

        // Two sprites on line 12: entries 3 (row 2) and 40 (row 7).
        oam[3][31:24] = 8'd10;
        oam[40][31:24] = 8'd5;
        runEval("two_hits", 0, 8'd12, -1, 0);

        // Stray starts at cycle 10 and on done are ignored.
        runEval("stray_start", 0, 8'd12, 10, 1);

        // Reset in the middle of a scan at address 30.
        applyStimulus(0, 8'd12);
        @(negedge clk);
        setStart(0, 1'b0, 8'd12);
        n = 0;
        snap(0, s);
        while (s.addr != 6'd30 && n < 100) begin
            @(negedge clk);
            snap(0, s);
            n++;
        end
        checkOutput("mid_reached_addr30", 32'(s.addr), 32'd30);
        reset = 1'b0;
        @(negedge clk);
        snap(0, s);
        reset = 1'b1;
        checkOutput("mid_rst_busy", 32'(s.busy), 32'd0);
        checkOutput("mid_rst_addr", 32'(s.addr), 32'd0);
        checkOutput("mid_rst_we", 32'(s.we), 32'd0);
        runEval("after_rst", 0, 8'd12, -1, 0);

        // No wrap-around: Y=250 never covers line 4.
        fillOam(8'd250);
        runEval("no_wrap", 0, 8'd4, -1, 0);

        // Ten sprites on one line: list saturates at eight.
        fillOam(8'd200);
        for (int i = 0; i < 10; i++) oam[i][31:24] = 8'd20;
        runEval("ten_hits", 0, 8'd20, -1, 0);

        // Last line of the frame.
        fillOam(8'd200);
        oam[17][31:24] = 8'd250;
        oam[20][31:24] = 8'd255;
        oam[30][31:24] = 8'd247;
        runEval("line255", 0, 8'd255, -1, 0);

        // 16-line sprites: entry 63 hits on its last row in DRAIN, then misses.
        fillOam(8'd200);
        oam[63][31:24] = 8'd100;
        runEval("tall_last_row", 1, 8'd115, -1, 0);
        runEval("tall_miss", 1, 8'd116, -1, 0);

        // Randomized OAM images, about a quarter of entries placed near the line.
        for (int it = 0; it < 16; it++) begin
            int sel;
            int h;
            logic [7:0] line;
            sel = it % 2;
            h = (sel == 0) ? 8 : 16;
            line = 8'($urandom_range(0, 255));
            for (int i = 0; i < 64; i++) begin
                oam[i] = $urandom;
                if ($urandom_range(0, 3) == 0)
                    oam[i][31:24] = line - 8'($urandom_range(0, h + 1));
            end
            runEval($sformatf("rand%0d", it), sel, line, -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
